// File: rtl/thread_pc_sched_pkg.sv
// Shared definitions for the barrel-thread fetch scheduler: thread index width
// and default PC parameters.
package thread_pkg;

    localparam int unsigned DEFAULT_PC_STEP  = 4;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    function automatic int tid_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/thread_pc_sched_if.sv
// Fetch-scheduler bus: control, redirect and host-load inputs, plus the
// issued PC/thread outputs. master drives the controls; slave is the scheduler.
interface thread_pc_sched_if
    import thread_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int PC_WIDTH    = 32
) ();
    localparam int TID_W = tid_width(NUM_THREADS);

    logic                   pc_en;
    logic [NUM_THREADS-1:0] thread_active;
    logic                   redirect_valid;
    logic [TID_W-1:0]       redirect_tid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   pc_load_we;
    logic [TID_W-1:0]       pc_load_tid;
    logic [PC_WIDTH-1:0]    pc_load_val;
    logic [PC_WIDTH-1:0]    pc_out;
    logic [TID_W-1:0]       tid_out;
    logic [NUM_THREADS-1:0] tid_onehot_out;
    logic                   issue_valid;

    modport master (
        output pc_en, thread_active, redirect_valid, redirect_tid, redirect_pc,
               pc_load_we, pc_load_tid, pc_load_val,
        input  pc_out, tid_out, tid_onehot_out, issue_valid
    );

    modport slave (
        input  pc_en, thread_active, redirect_valid, redirect_tid, redirect_pc,
               pc_load_we, pc_load_tid, pc_load_val,
        output pc_out, tid_out, tid_onehot_out, issue_valid
    );
endinterface

// File: rtl/thread_pc_sched_rr_arbiter.sv
// Combinational round-robin picker: first set mask bit after last_ptr,
// wrapping, with last_ptr itself considered last.
module rr_arbiter
    import thread_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = tid_width(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0] mask,
    input  logic [TID_W-1:0]       last_ptr,
    output logic [TID_W-1:0]       grant,
    output logic                   any_grant
);
    logic [TID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            idx = TID_W'((int'(last_ptr) + k) % NUM_THREADS);
            if (!any_grant && mask[idx]) begin
                any_grant = 1'b1;
                grant     = idx;
            end
        end
    end
endmodule

// File: rtl/thread_pc_sched.sv
// Barrel-thread fetch scheduler: one PC per hardware thread, round-robin issue
// over active threads, with MEM-stage redirects and host PC loads.
module thread_pc_sched
    import thread_pkg::*;
#(
    parameter int          NUM_THREADS = 4,
    parameter int          PC_WIDTH    = 32,
    parameter int unsigned PC_STEP     = DEFAULT_PC_STEP,
    parameter int unsigned RESET_PC    = DEFAULT_RESET_PC
) (
    input logic             clk,
    input logic             reset,
    thread_pc_sched_if.slave bus
);
    localparam int TID_W = tid_width(NUM_THREADS);
    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] STEP   = PC_WIDTH'(PC_STEP);

    logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
    logic [TID_W-1:0]       rr_ptr;
    logic [TID_W-1:0]       grant;
    logic                   any_grant;

    logic [PC_WIDTH-1:0]    pc_p1;
    logic [TID_W-1:0]       tid_p1;
    logic [NUM_THREADS-1:0] onehot_p1;
    logic                   vld_p1;

    rr_arbiter #(
        .NUM_THREADS (NUM_THREADS),
        .TID_W       (TID_W)
    ) u_arb (
        .mask      (bus.thread_active),
        .last_ptr  (rr_ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    logic issue_now;
    assign issue_now = bus.pc_en && any_grant;

    // Selection -> issue registers; PC array updated on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= TID_W'(NUM_THREADS - 1);
            pc_p1     <= RST_PC;
            tid_p1    <= '0;
            onehot_p1 <= '0;
            vld_p1    <= 1'b0;
            for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= RST_PC;
        end else begin
            if (bus.pc_en) begin
                if (any_grant) begin
                    pc_p1     <= pc_q[grant];
                    tid_p1    <= grant;
                    onehot_p1 <= NUM_THREADS'(1) << grant;
                    vld_p1    <= 1'b1;
                    rr_ptr    <= grant;
                end else begin
                    onehot_p1 <= '0;
                    vld_p1    <= 1'b0;
                end
            end
            // Out-of-range thread indices never match, so they are ignored
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (bus.redirect_valid && bus.redirect_tid == TID_W'(i))
                    pc_q[i] <= bus.redirect_pc;
                else if (bus.pc_load_we && bus.pc_load_tid == TID_W'(i))
                    pc_q[i] <= bus.pc_load_val;
                else if (issue_now && grant == TID_W'(i))
                    pc_q[i] <= pc_q[i] + STEP;
            end
        end
    end

    assign bus.pc_out         = pc_p1;
    assign bus.tid_out        = tid_p1;
    assign bus.tid_onehot_out = onehot_p1;
    assign bus.issue_valid    = vld_p1;
endmodule
